// File: rtl/ucode_pkg.sv
// Shared encodings for the microprogrammed control unit.
package ucode_pkg;

    // Sequencing op field of a microinstruction
    localparam logic [2:0] SEQ_CONT     = 3'b000;
    localparam logic [2:0] SEQ_JUMP     = 3'b001;
    localparam logic [2:0] SEQ_BR_T     = 3'b010;
    localparam logic [2:0] SEQ_BR_F     = 3'b011;
    localparam logic [2:0] SEQ_DISPATCH = 3'b100;
    localparam logic [2:0] SEQ_CALL     = 3'b101;
    localparam logic [2:0] SEQ_RET      = 3'b110;
    localparam logic [2:0] SEQ_HALT     = 3'b111;

    // Sequencer FSM state
    typedef logic [0:0] seq_state_t;
    localparam seq_state_t ST_RUN    = 1'b0;
    localparam seq_state_t ST_HALTED = 1'b1;

    // Condition select
    localparam int unsigned CC_W     = 4;
    localparam int unsigned NUM_COND = 9;

endpackage

// File: rtl/ustack.sv
// Parameterised LIFO holding micro-return addresses; no error handling here.
module ustack #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned W     = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push_i,
    input  logic         pop_i,
    input  logic [W-1:0] din_i,
    output logic         full_o,
    output logic         empty_o,
    output logic [W-1:0] top_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;

    logic [CNT_W-1:0] count_q, count_d;
    logic [W-1:0]     mem_q [DEPTH];
    logic             do_push, do_pop;
    logic [PTR_W-1:0] top_idx;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;
    assign top_idx = PTR_W'(count_q - CNT_W'(1));
    assign top_o   = mem_q[top_idx];

    // Occupancy update
    always_comb begin
        count_d = count_q;
        if (do_push) begin
            count_d = count_q + CNT_W'(1);
        end else if (do_pop) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Occupancy register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    // Entry storage; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem_q[PTR_W'(count_q)] <= din_i;
        end
    end

endmodule

// File: rtl/microprogram_sequencer.sv
// Micro-PC sequencer: picks the next control-store address each cycle.
module microprogram_sequencer
    import ucode_pkg::*;
#(
    parameter int unsigned UADDR_W     = 8,
    parameter int unsigned STACK_DEPTH = 4,
    parameter int unsigned RESET_ADDR  = 0
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [2:0]         seq_op,
    input  logic [UADDR_W-1:0] next_addr,
    input  logic [CC_W-1:0]    cc,
    input  logic [8:0]         conditional_wires,
    input  logic [UADDR_W-1:0] dispatch_addr,
    input  logic               stall,
    output logic [UADDR_W-1:0] upc,
    output logic               status,
    output logic               halted,
    output logic               stack_ovf,
    output logic               stack_unf
);

    localparam logic [UADDR_W-1:0] RST_UADDR = UADDR_W'(RESET_ADDR);

    seq_state_t         state_q, state_d;
    logic [UADDR_W-1:0] upc_q, upc_d;
    logic               ovf_q, ovf_d;
    logic               unf_q, unf_d;
    logic [UADDR_W-1:0] upc_inc;
    logic               push, pop;
    logic               stk_full, stk_empty;
    logic [UADDR_W-1:0] stk_top;

    assign upc_inc   = upc_q + UADDR_W'(1);
    assign upc       = upc_q;
    assign halted    = (state_q == ST_HALTED);
    assign stack_ovf = ovf_q;
    assign stack_unf = unf_q;

    // Condition select; codes past the last flag read as 0
    always_comb begin
        status = 1'b0;
        if (32'(cc) < NUM_COND) begin
            status = conditional_wires[cc];
        end
    end

    // Next-state and next-address selection
    always_comb begin
        state_d = state_q;
        upc_d   = upc_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        push    = 1'b0;
        pop     = 1'b0;
        if (state_q == ST_RUN && !stall) begin
            case (seq_op)
                SEQ_CONT:     upc_d = upc_inc;
                SEQ_JUMP:     upc_d = next_addr;
                SEQ_BR_T:     upc_d = status ? next_addr : upc_inc;
                SEQ_BR_F:     upc_d = status ? upc_inc : next_addr;
                SEQ_DISPATCH: upc_d = dispatch_addr;
                SEQ_CALL: begin
                    upc_d = next_addr;
                    if (stk_full) begin
                        ovf_d = 1'b1;
                    end else begin
                        push = 1'b1;
                    end
                end
                SEQ_RET: begin
                    if (stk_empty) begin
                        upc_d = RST_UADDR;
                        unf_d = 1'b1;
                    end else begin
                        pop   = 1'b1;
                        upc_d = stk_top;
                    end
                end
                default:      state_d = ST_HALTED;
            endcase
        end
    end

    // State, micro-PC and sticky flag registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_RUN;
            upc_q   <= RST_UADDR;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            upc_q   <= upc_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    ustack #(
        .DEPTH (STACK_DEPTH),
        .W     (UADDR_W)
    ) u_stack (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push),
        .pop_i   (pop),
        .din_i   (upc_inc),
        .full_o  (stk_full),
        .empty_o (stk_empty),
        .top_o   (stk_top)
    );

endmodule

// File: tb/tb_microprogram_sequencer.sv
// Directed bench for microprogram_sequencer.
module tb_microprogram_sequencer;

    localparam logic [2:0] OP_CONT = 3'b000;
    localparam logic [2:0] OP_JUMP = 3'b001;
    localparam logic [2:0] OP_BR_T = 3'b010;
    localparam logic [2:0] OP_BR_F = 3'b011;
    localparam logic [2:0] OP_DISP = 3'b100;
    localparam logic [2:0] OP_CALL = 3'b101;
    localparam logic [2:0] OP_RET  = 3'b110;
    localparam logic [2:0] OP_HALT = 3'b111;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] seq_op;
    logic [7:0] next_addr;
    logic [3:0] cc;
    logic [8:0] conditional_wires;
    logic [7:0] dispatch_addr;
    logic       stall;
    logic [7:0] upc;
    logic       status;
    logic       halted;
    logic       stack_ovf;
    logic       stack_unf;

    int vecs = 0;
    int errs = 0;

    microprogram_sequencer #(
        .UADDR_W     (8),
        .STACK_DEPTH (4),
        .RESET_ADDR  (0)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .seq_op            (seq_op),
        .next_addr         (next_addr),
        .cc                (cc),
        .conditional_wires (conditional_wires),
        .dispatch_addr     (dispatch_addr),
        .stall             (stall),
        .upc               (upc),
        .status            (status),
        .halted            (halted),
        .stack_ovf         (stack_ovf),
        .stack_unf         (stack_unf)
    );

    always #5 clk = ~clk;

    // Present one microinstruction and let one rising edge pass
    task automatic drive(input logic [2:0] op, input logic [7:0] na);
        seq_op    = op;
        next_addr = na;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; seq_op = OP_CONT; next_addr = '0; cc = '0;
        conditional_wires = '0; dispatch_addr = '0; stall = 1'b0;
        @(posedge clk); #1;
        vecs++;
        if (upc !== 8'h00 || halted !== 1'b0 || stack_ovf !== 1'b0 || stack_unf !== 1'b0) begin
            errs++;
            $display("FAIL reset: upc=%h halted=%b ovf=%b unf=%b, want 00 0 0 0", upc, halted, stack_ovf, stack_unf);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_cont_jump();
        logic [7:0] exp_seq [5];
        exp_seq = '{8'h01, 8'h02, 8'h03, 8'hFF, 8'h00};
        for (int i = 0; i < 5; i++) begin
            drive((i == 3) ? OP_JUMP : OP_CONT, 8'hFF);
            vecs++;
            if (upc !== exp_seq[i]) begin
                errs++;
                $display("FAIL cont_jump[%0d]: upc=%h want %h", i, upc, exp_seq[i]);
            end
        end
    endtask

    task automatic test_branch();
        cc = 4'd3; conditional_wires = 9'h008;
        #1;
        vecs++;
        if (status !== 1'b1) begin
            errs++; $display("FAIL status_cc3: status=%b want 1", status);
        end
        drive(OP_BR_T, 8'h40);
        vecs++;
        if (upc !== 8'h40) begin errs++; $display("FAIL br_t_taken: upc=%h want 40", upc); end
        conditional_wires = 9'h000;
        drive(OP_BR_T, 8'h70);
        vecs++;
        if (upc !== 8'h41) begin errs++; $display("FAIL br_t_not_taken: upc=%h want 41", upc); end
        cc = 4'd12; conditional_wires = 9'h1FF;
        #1;
        vecs++;
        if (status !== 1'b0) begin errs++; $display("FAIL status_cc12: status=%b want 0", status); end
        drive(OP_BR_F, 8'h80);
        vecs++;
        if (upc !== 8'h80) begin errs++; $display("FAIL br_f_cc12: upc=%h want 80", upc); end
        cc = 4'd8; conditional_wires = 9'h100;
        drive(OP_BR_F, 8'h90);
        vecs++;
        if (upc !== 8'h81) begin errs++; $display("FAIL br_f_cc8: upc=%h want 81", upc); end
        dispatch_addr = 8'hA7;
        drive(OP_DISP, 8'h00);
        vecs++;
        if (upc !== 8'hA7) begin errs++; $display("FAIL dispatch: upc=%h want a7", upc); end
    endtask

    task automatic test_call_ret();
        logic [7:0] ops_exp [13];
        logic [2:0] ops     [13];
        logic [7:0] tgts    [13];
        ops     = '{OP_JUMP, OP_CALL, OP_RET, OP_CALL, OP_CALL, OP_CALL, OP_CALL,
                    OP_CALL, OP_RET, OP_RET, OP_RET, OP_RET, OP_JUMP};
        tgts    = '{8'h05, 8'h20, 8'h00, 8'h30, 8'h31, 8'h32, 8'h33,
                    8'h50, 8'h00, 8'h00, 8'h00, 8'h00, 8'h10};
        ops_exp = '{8'h05, 8'h20, 8'h06, 8'h30, 8'h31, 8'h32, 8'h33,
                    8'h50, 8'h33, 8'h32, 8'h31, 8'h07, 8'h10};
        for (int i = 0; i < 13; i++) begin
            drive(ops[i], tgts[i]);
            vecs++;
            if (upc !== ops_exp[i]) begin
                errs++; $display("FAIL call_ret[%0d]: upc=%h want %h", i, upc, ops_exp[i]);
            end
            if (i == 6) begin
                vecs++;
                if (stack_ovf !== 1'b0) begin errs++; $display("FAIL ovf_at_full: ovf=%b want 0", stack_ovf); end
            end
            if (i == 7) begin
                vecs++;
                if (stack_ovf !== 1'b1) begin errs++; $display("FAIL ovf_set: ovf=%b want 1", stack_ovf); end
            end
        end
        vecs++;
        if (stack_unf !== 1'b0) begin errs++; $display("FAIL unf_early: unf=%b want 0", stack_unf); end
        drive(OP_RET, 8'h00);
        vecs++;
        if (upc !== 8'h00 || stack_unf !== 1'b1) begin
            errs++; $display("FAIL ret_empty: upc=%h unf=%b want 00 1", upc, stack_unf);
        end
        drive(OP_CONT, 8'h00);
        drive(OP_JUMP, 8'h44);
        vecs++;
        if (upc !== 8'h44 || stack_unf !== 1'b1 || stack_ovf !== 1'b1) begin
            errs++; $display("FAIL sticky: upc=%h unf=%b ovf=%b want 44 1 1", upc, stack_unf, stack_ovf);
        end
    endtask

    task automatic test_stall();
        drive(OP_JUMP, 8'h08);
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(OP_CALL, 8'h60);
            vecs++;
            if (upc !== 8'h08) begin errs++; $display("FAIL stall_hold[%0d]: upc=%h want 08", i, upc); end
        end
        stall = 1'b0;
        drive(OP_CALL, 8'h60);
        vecs++;
        if (upc !== 8'h60) begin errs++; $display("FAIL stall_release: upc=%h want 60", upc); end
        drive(OP_RET, 8'h00);
        vecs++;
        if (upc !== 8'h09) begin errs++; $display("FAIL stall_ret1: upc=%h want 09", upc); end
        drive(OP_JUMP, 8'h2A);
        drive(OP_RET, 8'h00);
        vecs++;
        if (upc !== 8'h00) begin errs++; $display("FAIL stall_ret2: upc=%h want 00", upc); end
    endtask

    task automatic test_halt();
        drive(OP_JUMP, 8'h22);
        drive(OP_HALT, 8'h00);
        vecs++;
        if (upc !== 8'h22 || halted !== 1'b1) begin
            errs++; $display("FAIL halt_enter: upc=%h halted=%b want 22 1", upc, halted);
        end
        for (int i = 0; i < 10; i++) begin
            stall = 1'($urandom_range(0, 1));
            conditional_wires = 9'($urandom);
            cc = 4'($urandom);
            drive(3'($urandom_range(0, 6)), 8'($urandom));
            vecs++;
            if (upc !== 8'h22 || halted !== 1'b1) begin
                errs++; $display("FAIL halt_hold[%0d]: upc=%h halted=%b want 22 1", i, upc, halted);
            end
        end
        stall = 1'b0;
        #3;
        rst_n = 1'b0;
        #1;
        vecs++;
        if (upc !== 8'h00 || halted !== 1'b0 || stack_ovf !== 1'b0 || stack_unf !== 1'b0) begin
            errs++; $display("FAIL async_reset: upc=%h halted=%b ovf=%b unf=%b want 00 0 0 0",
                             upc, halted, stack_ovf, stack_unf);
        end
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back();
        drive(OP_CONT, 8'h00);
        vecs++;
        if (upc !== 8'h01) begin errs++; $display("FAIL post_reset_cont: upc=%h want 01", upc); end
        drive(OP_RET, 8'h00);
        vecs++;
        if (upc !== 8'h00 || stack_unf !== 1'b1) begin
            errs++; $display("FAIL post_reset_stack_empty: upc=%h unf=%b want 00 1", upc, stack_unf);
        end
    endtask

    initial begin
        test_reset();
        test_cont_jump();
        test_branch();
        test_call_ret();
        test_stall();
        test_halt();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
        $finish;
    end

endmodule
